// File: rtl/decode_packet.sv
// decode_packet: reassembles 19 x 64-bit flits into a 1024-bit payload plus
// 10-bit destination address, checking flit order and source consistency.
// Downstream handshake: a packet is transferred on a clock edge where
// decode_valid_o && decode_ready_i; decode_valid_o never drops before that
// edge and the payload/address/src/ttl outputs stay constant while it is high.
// Upstream: a flit is taken on an edge where fifo_valid_i && fifo_ready_o.
module decode_packet #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int NUMBER_PACKET     = 19,
    parameter int AURORA_DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_valid_i,
    output logic                         fifo_ready_o,
    input  logic [AURORA_DATA_WIDTH-1:0] fifo_data_i,
    output logic                         decode_valid_o,
    input  logic                         decode_ready_i,
    output logic [DATA_WIDTH-1:0]        decode_data_o,
    output logic [ADDR_WIDTH-1:0]        decode_dst_addr_o,
    output logic [1:0]                   decode_src_router_o,
    output logic [1:0]                   decode_ttl_o,
    output logic                         decode_err_o,
    output logic [15:0]                  drop_cnt_o
);

    // Flit slice geometry: every flit but the last carries SLICE buffer bits;
    // the last one carries the remaining LAST_W bits at the bottom of its slice.
    localparam int SLICE  = AURORA_DATA_WIDTH - 9;
    localparam int LAST_W = DATA_DFX_WIDTH - (NUMBER_PACKET - 1) * SLICE;
    localparam logic [4:0] LAST_IDX = 5'(NUMBER_PACKET - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DROP    = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic [4:0] exp_num;
    logic [4:0] exp_next;

    logic [DATA_DFX_WIDTH-1:0] buffer;
    logic [1:0]                src_latched;
    logic [1:0]                ttl_latched;
    logic                      err;
    logic [15:0]               drop_cnt;

    // Flit fields
    logic [SLICE-1:0] slice;
    logic [1:0]       ttl;
    logic [4:0]       pkt_num;
    logic [1:0]       src;
    logic             accept;
    logic             in_seq;
    logic             good;
    logic             bad;

    assign slice   = fifo_data_i[AURORA_DATA_WIDTH-1:9];
    assign ttl     = fifo_data_i[8:7];
    assign pkt_num = fifo_data_i[6:2];
    assign src     = fifo_data_i[1:0];

    // A flit is in sequence when it is the expected index and, past flit 0,
    // comes from the source latched at flit 0. exp_num never exceeds the
    // last index, so out-of-range packet numbers fail the equality test.
    assign accept = fifo_valid_i && fifo_ready_o;
    assign in_seq = (pkt_num == exp_num) &&
                    ((exp_num == 5'd0) || (src == src_latched));
    assign good   = accept && (state == COLLECT) && in_seq;
    assign bad    = accept && (state == COLLECT) && !in_seq;

    // State register and expected-flit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            exp_num <= 5'd0;
        end else begin
            state   <= state_next;
            exp_num <= exp_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        exp_next   = exp_num;
        case (state)
            COLLECT: begin
                if (good) begin
                    if (exp_num == LAST_IDX) begin
                        state_next = OUTPUT;
                        exp_next   = 5'd0;
                    end else begin
                        exp_next = exp_num + 5'd1;
                    end
                end else if (bad) begin
                    // An error on a flit numbered as the last one already
                    // marks a packet boundary, so no resynchronisation needed.
                    exp_next = 5'd0;
                    if (pkt_num != LAST_IDX) begin
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && (pkt_num == LAST_IDX)) begin
                    state_next = COLLECT;
                    exp_next   = 5'd0;
                end
            end
            OUTPUT: begin
                if (decode_ready_i) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
                exp_next   = 5'd0;
            end
        endcase
    end

    // Reassembly buffer, latched header fields, error pulse and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer      <= '0;
            src_latched <= 2'd0;
            ttl_latched <= 2'd0;
            err         <= 1'b0;
            drop_cnt    <= 16'd0;
        end else begin
            err <= bad;
            if (bad && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (good) begin
                for (int k = 0; k < NUMBER_PACKET - 1; k++) begin
                    if (exp_num == 5'(k)) begin
                        buffer[k*SLICE +: SLICE] <= slice;
                    end
                end
                if (exp_num == LAST_IDX) begin
                    buffer[DATA_DFX_WIDTH-1 -: LAST_W] <= fifo_data_i[9 +: LAST_W];
                    ttl_latched <= ttl;
                end
                if (exp_num == 5'd0) begin
                    src_latched <= src;
                end
            end
        end
    end

    // Output decode
    always_comb begin
        fifo_ready_o        = !rst && (state != OUTPUT);
        decode_valid_o      = !rst && (state == OUTPUT);
        decode_data_o       = buffer[DATA_DFX_WIDTH-1:ADDR_WIDTH];
        decode_dst_addr_o   = buffer[ADDR_WIDTH-1:0];
        decode_src_router_o = src_latched;
        decode_ttl_o        = ttl_latched;
        decode_err_o        = err;
        drop_cnt_o          = drop_cnt;
    end

endmodule

// File: tb/tb_decode_packet.sv
// Testbench for decode_packet: directed scenarios plus randomized packets,
// checked against a flit-stream reference model and an expected-packet queue.
module tb_decode_packet;

    localparam int DW = 1024;
    localparam int AW = 10;
    localparam int BW = DW + AW;
    localparam int SW = BW + 4;

    logic           clk;
    logic           rst;
    logic           fifo_valid_i;
    logic           fifo_ready_o;
    logic [63:0]    fifo_data_i;
    logic           decode_valid_o;
    logic           decode_ready_i;
    logic [DW-1:0]  decode_data_o;
    logic [AW-1:0]  decode_dst_addr_o;
    logic [1:0]     decode_src_router_o;
    logic [1:0]     decode_ttl_o;
    logic           decode_err_o;
    logic [15:0]    drop_cnt_o;

    decode_packet dut (
        .clk                 (clk),
        .rst                 (rst),
        .fifo_valid_i        (fifo_valid_i),
        .fifo_ready_o        (fifo_ready_o),
        .fifo_data_i         (fifo_data_i),
        .decode_valid_o      (decode_valid_o),
        .decode_ready_i      (decode_ready_i),
        .decode_data_o       (decode_data_o),
        .decode_dst_addr_o   (decode_dst_addr_o),
        .decode_src_router_o (decode_src_router_o),
        .decode_ttl_o        (decode_ttl_o),
        .decode_err_o        (decode_err_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scoreboard ----------------
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] got_pkt;
    logic [SW-1:0] exp_pkt;
    int            err_seen = 0;
    bit            rand_ready = 0;

    // Packets leaving the DUT are compared at the handshake edge.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            if (decode_err_o === 1'b1) err_seen++;
            if (decode_valid_o === 1'b1 && decode_ready_i === 1'b1) begin
                got_pkt = {decode_data_o, decode_dst_addr_o, decode_src_router_o, decode_ttl_o};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_packet got dst=%h src=%0d ttl=%0d required none",
                             decode_dst_addr_o, decode_src_router_o, decode_ttl_o);
                end else begin
                    exp_pkt = exp_q.pop_front();
                    if (got_pkt !== exp_pkt) begin
                        n_fail++;
                        $display("FAIL packet_content got low=%h dst=%h src=%0d ttl=%0d required low=%h dst=%h src=%0d ttl=%0d",
                                 got_pkt[SW-1 -: 64], got_pkt[13:4], got_pkt[3:2], got_pkt[1:0],
                                 exp_pkt[SW-1 -: 64], exp_pkt[13:4], exp_pkt[3:2], exp_pkt[1:0]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rand_ready) decode_ready_i = 1'($urandom_range(0, 1));
    end

    // ---------------- reference model (flit-stream level) ----------------
    bit             m_drop;
    int             m_exp;
    logic [1:0]     m_src;
    logic [BW-1:0]  m_buf;
    int             m_errors = 0;
    int             m_drops;

    task automatic model_reset();
        m_drop = 0;
        m_exp  = 0;
        m_src  = 2'd0;
        m_buf  = '0;
        m_drops = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [63:0] f);
        int pn;
        logic [1:0] s;
        pn = int'(f[6:2]);
        s  = f[1:0];
        if (m_drop) begin
            if (pn == 18) begin
                m_drop = 0;
                m_exp  = 0;
            end
        end else if (pn == m_exp && (m_exp == 0 || s == m_src)) begin
            if (pn < 18) m_buf[pn*55 +: 55] = f[63:9];
            else         m_buf[1033:990]    = f[52:9];
            if (pn == 0) m_src = s;
            if (pn == 18) begin
                exp_q.push_back({m_buf, m_src, f[8:7]});
                m_exp = 0;
            end else begin
                m_exp++;
            end
        end else begin
            m_errors++;
            if (m_drops < 65535) m_drops++;
            if (pn == 18) m_exp = 0;
            else          m_drop = 1;
        end
    endtask

    function automatic logic [63:0] make_flit(input logic [BW-1:0] b, input int k,
                                              input logic [1:0] s, input logic [1:0] t,
                                              input logic [10:0] pad);
        logic [54:0] sl;
        if (k < 18) sl = b[k*55 +: 55];
        else        sl = {pad, b[1033:990]};
        return {sl, t, 5'(k), s};
    endfunction

    function automatic logic [BW-1:0] rand_buf();
        logic [BW-1:0] b;
        for (int i = 0; i < BW; i += 32) b[i +: 32] = $urandom;
        b[1033:1024] = 10'($urandom);
        return b;
    endfunction

    // ---------------- drivers ----------------
    // Presents one flit and waits (bounded) for it to be taken.
    task automatic send_flit(input logic [63:0] f, output time acc_time);
        bit ok;
        ok = 0;
        acc_time = 0;
        fifo_data_i  = f;
        fifo_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (fifo_ready_o === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flit_accept_timeout got ready=%b required ready=1 flit=%h", fifo_ready_o, f);
            fifo_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        acc_time = $time;
        model_accept(f);
        #1 fifo_valid_i = 1'b0;
    endtask

    task automatic send_range(input logic [BW-1:0] b, input logic [1:0] s, input logic [1:0] t,
                              input int first, input int last, output time t0);
        time ta;
        t0 = 0;
        for (int k = first; k <= last; k++) begin
            send_flit(make_flit(b, k, s, t, 11'd0), ta);
            if (k == first) t0 = ta;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fifo_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && decode_valid_o === 1'b0) break;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (fifo_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got %b required 0", fifo_ready_o);
        end
        n_checks++;
        if ({decode_valid_o, decode_err_o, drop_cnt_o, decode_src_router_o, decode_ttl_o, decode_dst_addr_o} !== '0
            || decode_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b err=%b drop=%h src=%0d ttl=%0d dst=%h required all 0",
                     decode_valid_o, decode_err_o, drop_cnt_o, decode_src_router_o, decode_ttl_o, decode_dst_addr_o);
        end
        release_reset();
        n_checks++;
        if (fifo_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready got %b required 1", fifo_ready_o);
        end
    endtask

    task automatic test_nominal();
        logic [BW-1:0] b;
        time t0;
        b = {{32{32'h1234_5678}}, 10'h2A5};
        decode_ready_i = 1'b1;
        send_range(b, 2'd2, 2'd3, 0, 17, t0);
        n_checks++;
        if (decode_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_early_valid got %b required 0", decode_valid_o);
        end
        send_range(b, 2'd2, 2'd3, 18, 18, t0);
        n_checks++;
        if (decode_valid_o !== 1'b1 || decode_data_o !== b[1033:10] || decode_dst_addr_o !== 10'h2A5
            || decode_src_router_o !== 2'd2 || decode_ttl_o !== 2'd3 || decode_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_outputs got valid=%b dst=%h src=%0d ttl=%0d err=%b required valid=1 dst=2a5 src=2 ttl=3 err=0",
                     decode_valid_o, decode_dst_addr_o, decode_src_router_o, decode_ttl_o, decode_err_o);
        end
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0 || err_seen != m_errors || drop_cnt_o !== 16'(m_drops)) begin
            n_fail++;
            $display("FAIL nominal_drain got pending=%0d errs=%0d drop=%0d required pending=0 errs=%0d drop=%0d",
                     exp_q.size(), err_seen, drop_cnt_o, m_errors, m_drops);
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] b1, b2;
        time t1, t2;
        b1 = rand_buf();
        b2 = rand_buf();
        decode_ready_i = 1'b1;
        send_range(b1, 2'd1, 2'd0, 0, 18, t1);
        send_range(b2, 2'd3, 2'd1, 0, 18, t2);
        n_checks++;
        if (t2 - t1 != 200) begin
            n_fail++;
            $display("FAIL back_to_back_spacing got %0t required 200", t2 - t1);
        end
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] b1, b2;
        logic [SW-1:0] held;
        time t0;
        b1 = rand_buf();
        b2 = rand_buf();
        decode_ready_i = 1'b0;
        send_range(b1, 2'd0, 2'd2, 0, 18, t0);
        held = exp_q[0];
        fifo_data_i  = make_flit(b2, 0, 2'd1, 2'd1, 11'd0);
        fifo_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (decode_valid_o !== 1'b1 || fifo_ready_o !== 1'b0
                || {decode_data_o, decode_dst_addr_o, decode_src_router_o, decode_ttl_o} !== held) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle=%0d got valid=%b ready=%b dst=%h required valid=1 ready=0 dst=%h",
                         i, decode_valid_o, fifo_ready_o, decode_dst_addr_o, held[13:4]);
            end
        end
        n_checks++;
        if (exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL backpressure_pending got %0d required 1", exp_q.size());
        end
        decode_ready_i = 1'b1;
        send_range(b2, 2'd1, 2'd1, 0, 18, t0);
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL backpressure_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_skipped_flit();
        logic [BW-1:0] b;
        time ta;
        int e0;
        do_reset();
        release_reset();
        e0 = err_seen;
        b = rand_buf();
        decode_ready_i = 1'b1;
        send_range(b, 2'd2, 2'd1, 0, 4, ta);
        send_flit(make_flit(b, 6, 2'd2, 2'd1, 11'd0), ta);
        n_checks++;
        if (decode_err_o !== 1'b1 || drop_cnt_o !== 16'd1) begin
            n_fail++;
            $display("FAIL skip_err got err=%b drop=%0d required err=1 drop=1", decode_err_o, drop_cnt_o);
        end
        send_range(b, 2'd2, 2'd1, 7, 18, ta);
        wait_idle();
        n_checks++;
        if (err_seen - e0 != 1 || drop_cnt_o !== 16'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL skip_discard got errs=%0d drop=%0d pending=%0d required errs=1 drop=1 pending=0",
                     err_seen - e0, drop_cnt_o, exp_q.size());
        end
        b = rand_buf();
        send_range(b, 2'd0, 2'd3, 0, 18, ta);
        n_checks++;
        if (decode_valid_o !== 1'b1 || decode_data_o !== b[1033:10]) begin
            n_fail++;
            $display("FAIL skip_recover got valid=%b required 1", decode_valid_o);
        end
        wait_idle();
    endtask

    task automatic test_last_flit_err();
        logic [BW-1:0] b;
        time ta;
        int e0;
        e0 = err_seen;
        b = rand_buf();
        decode_ready_i = 1'b1;
        send_range(b, 2'd3, 2'd2, 0, 16, ta);
        send_range(b, 2'd3, 2'd2, 18, 18, ta);
        n_checks++;
        if (decode_err_o !== 1'b1 || drop_cnt_o !== 16'd2) begin
            n_fail++;
            $display("FAIL last_err got err=%b drop=%0d required err=1 drop=2", decode_err_o, drop_cnt_o);
        end
        b = rand_buf();
        send_range(b, 2'd1, 2'd0, 0, 18, ta);
        n_checks++;
        if (decode_valid_o !== 1'b1 || decode_src_router_o !== 2'd1) begin
            n_fail++;
            $display("FAIL last_err_recover got valid=%b src=%0d required valid=1 src=1",
                     decode_valid_o, decode_src_router_o);
        end
        wait_idle();
        n_checks++;
        if (err_seen - e0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL last_err_count got errs=%0d pending=%0d required errs=1 pending=0",
                     err_seen - e0, exp_q.size());
        end
    endtask

    task automatic test_src_mismatch();
        logic [BW-1:0] b;
        time ta;
        int e0;
        e0 = err_seen;
        b = rand_buf();
        decode_ready_i = 1'b1;
        send_range(b, 2'd1, 2'd0, 0, 2, ta);
        send_range(b, 2'd2, 2'd0, 3, 3, ta);
        n_checks++;
        if (decode_err_o !== 1'b1 || drop_cnt_o !== 16'd3) begin
            n_fail++;
            $display("FAIL src_mismatch_err got err=%b drop=%0d required err=1 drop=3", decode_err_o, drop_cnt_o);
        end
        send_range(b, 2'd1, 2'd0, 4, 18, ta);
        wait_idle();
        n_checks++;
        if (err_seen - e0 != 1 || exp_q.size() != 0 || decode_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL src_mismatch_drop got errs=%0d valid=%b required errs=1 valid=0",
                     err_seen - e0, decode_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] b;
        time ta;
        b = rand_buf();
        decode_ready_i = 1'b1;
        send_range(b, 2'd2, 2'd2, 0, 8, ta);
        do_reset();
        release_reset();
        n_checks++;
        if (decode_valid_o !== 1'b0 || decode_err_o !== 1'b0 || drop_cnt_o !== 16'd0
            || decode_data_o !== '0 || decode_dst_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got valid=%b err=%b drop=%0d required all 0",
                     decode_valid_o, decode_err_o, drop_cnt_o);
        end
        b = rand_buf();
        for (int k = 0; k < 19; k++) send_flit(make_flit(b, k, 2'd3, 2'd1, 11'h7FF), ta);
        n_checks++;
        if (decode_valid_o !== 1'b1 || decode_data_o !== b[1033:10] || decode_dst_addr_o !== b[9:0]) begin
            n_fail++;
            $display("FAIL padding_ignored got valid=%b top=%h required valid=1 top=%h",
                     decode_valid_o, decode_data_o[1023:980], b[1033:990]);
        end
        wait_idle();
    endtask

    task automatic test_random();
        logic [BW-1:0] b;
        logic [63:0] f;
        logic [1:0] s, t;
        time ta;
        int ck, kind;
        rand_ready = 1;
        for (int p = 0; p < 10; p++) begin
            b = rand_buf();
            s = 2'($urandom);
            t = 2'($urandom);
            ck = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 18)) : -1;
            kind = int'($urandom_range(0, 1));
            for (int k = 0; k < 19; k++) begin
                f = make_flit(b, k, s, t, 11'($urandom));
                if (k == ck) begin
                    if (kind == 0) f[6:2] = 5'(k + int'($urandom_range(1, 31)));
                    else           f[1:0] = s ^ 2'($urandom_range(1, 3));
                end
                send_flit(f, ta);
            end
        end
        rand_ready = 0;
        @(negedge clk);
        decode_ready_i = 1'b1;
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0 || err_seen != m_errors || drop_cnt_o !== 16'(m_drops)) begin
            n_fail++;
            $display("FAIL random_totals got pending=%0d errs=%0d drop=%0d required pending=0 errs=%0d drop=%0d",
                     exp_q.size(), err_seen, drop_cnt_o, m_errors, m_drops);
        end
    endtask

    task automatic test_saturation();
        time ta;
        do_reset();
        release_reset();
        decode_ready_i = 1'b1;
        for (int i = 0; i < 65540; i++) send_flit({55'd0, 2'd0, 5'd18, 2'd0}, ta);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (drop_cnt_o !== 16'hFFFF || m_drops != 65535) begin
            n_fail++;
            $display("FAIL drop_saturate got %h required ffff", drop_cnt_o);
        end
        n_checks++;
        if (err_seen != m_errors || decode_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_errs got errs=%0d valid=%b required errs=%0d valid=0",
                     err_seen, decode_valid_o, m_errors);
        end
    endtask

    initial begin
        rst            = 1'b1;
        fifo_valid_i   = 1'b0;
        fifo_data_i    = '0;
        decode_ready_i = 1'b0;
        model_reset();
        test_reset();
        test_nominal();
        test_back_to_back();
        test_backpressure();
        test_skipped_flit();
        test_last_flit_err();
        test_src_mismatch();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_packet.md
Name: decode_packet

Overview:
- Receive-side counterpart of the packet encoder. Accepts 64-bit flits from the Aurora RX FIFO and reassembles each 19-flit packet into the 1024-bit payload plus the 10-bit destination address.
- Checks flit sequence and source consistency, and hands complete packets to the router controller / output arbiter over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 1024, reassembled payload width
- ADDR_WIDTH, 10, destination address width carried in the low bits of the packet
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), reassembly buffer width
- NUMBER_PACKET, 19, flits per packet
- AURORA_DATA_WIDTH, 64, flit width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset (single clock domain)
- fifo_valid_i  in  1  RX FIFO holds a flit
- fifo_ready_o  out  1  block accepts a flit this cycle
- fifo_data_i  in  64  flit
- decode_valid_o  out  1  reassembled packet available
- decode_ready_i  in  1  consumer takes the packet
- decode_data_o  out  1024  payload = buffer[1033:10]
- decode_dst_addr_o  out  10  buffer[9:0]
- decode_src_router_o  out  2  source router of the packet
- decode_ttl_o  out  2  TTL field of the last flit
- decode_err_o  out  1  one-cycle pulse per protocol error
- drop_cnt_o  out  16  count of discarded packets, saturating

Behaviour:
- Flit format: [63:9] 55-bit payload slice, [8:7] TTL, [6:2] pkt_number, [1:0] src_router.
  - Flit k (k=0..17) carries buffer[k*55 +: 55].
  - Flit 18 carries buffer[1033:990] in bits [52:9]; bits [63:53] are padding and are ignored.
- Accept occurs when fifo_valid_i && fifo_ready_o. fifo_ready_o is combinational: 1 in COLLECT and DROP, 0 in OUTPUT and during rst.
- States:
  - COLLECT: expected counter exp (5 bits) starts at 0.
  - On accept, when pkt_number==exp and (exp==0 or src==latched src):
    - store the slice at exp
    - exp==0 latches src_router
    - exp==18 latches TTL, sets exp=0 and goes to OUTPUT
    - otherwise exp++
  - On accept, when pkt_number!=exp, pkt_number>18, or src mismatch: decode_err_o=1 next cycle and drop_cnt++.
    - If pkt_number==18: stay in COLLECT with exp=0.
    - Otherwise: go to DROP.
  - DROP: discard flits. Accepting a flit with pkt_number==18 returns to COLLECT with exp=0. No further errors or counts are raised while in DROP.
  - OUTPUT: decode_valid_o=1; outputs are stable until the handshake.
    - decode_valid_o && decode_ready_i returns to COLLECT; decode_valid_o is 0 the next cycle.
    - No flits are accepted while in OUTPUT.
- Latency: decode_valid_o rises on the cycle after the accept of flit 18. Back-to-back minimum is 20 cycles per packet with ready held high.
- Buffer is not cleared between packets. A dropped packet never asserts decode_valid_o.
- drop_cnt_o saturates at 0xFFFF.
- Reset values (rst high at a clock edge): all outputs 0, state COLLECT, exp 0, buffer 0, drop_cnt 0. Reset mid-packet or in OUTPUT discards the partial or pending packet without error.
- Simultaneous events: decode_ready_i while decode_valid_o=0 is ignored. fifo_valid_i in OUTPUT is held off (FIFO retains the flit).

Test Plan:
- Nominal: 19 flits for data=1024'h1234…, dst=10'h2A5, src=2, TTL=3, consumer ready=1 -> decode_valid_o 1 cycle after flit 18; data, dst, src, ttl match exactly; err=0.
- Output backpressure: decode_ready_i=0 for 10 cycles after valid -> outputs stable, fifo_ready_o=0, next packet's flit 0 is not accepted until ready; then it is accepted normally.
- Skipped flit: send pkt 0..4, then pkt 6 -> err pulse, drop_cnt=1, remaining flits discarded through pkt 18; the following clean packet decodes correctly.
- Error on last flit: send pkt 0..16, then pkt 18 -> err, drop_cnt=1, no DROP state; the next packet is accepted starting at flit 0.
- Source mismatch: flit 0 src=1, flit 3 src=2 -> err, DROP; no decode_valid_o for that packet.
- Reset mid-packet at flit 9 -> all outputs 0, drop_cnt 0; a new full packet decodes. Padding bits [63:53]=all-ones on flit 18 -> ignored, data correct.
